// File: rtl/data_store_buffer_pkg.sv
// Shared constants for the store buffer slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// WORD_LSB matches data_memory's word indexing, where the word index is address[31:2].
package data_store_buffer_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_LSB   = 2;

endpackage

// File: rtl/data_store_buffer_if.sv
// Bundle of the store, drain, load and data_memory port signals around the store buffer.
// Latency: n/a (wires only).
// Backpressure: st_ready gates st_valid; drain_en grants the data_memory write port.
// Ports: the slave modport is the buffer side; the master modport is the MEM stage, hazard unit and memory side.
interface data_store_buffer_if
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              drain_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] ld_data;
    logic              ld_hit;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_write_data;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output st_valid, st_addr, st_data, drain_en, ld_addr, mem_read_data,
        input  st_ready, ld_data, ld_hit, dm_write, dm_address, dm_write_data, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, drain_en, ld_addr, mem_read_data,
        output st_ready, ld_data, ld_hit, dm_write, dm_address, dm_write_data, empty, count
    );

endinterface

// File: rtl/data_store_buffer_sb_fwd_select.sv
// Forwarding priority selector: picks the youngest occupied entry whose word address matches.
// Latency: combinational.
// Backpressure: none.
// Ports: match/occupied per-entry vectors and head pointer in; hit flag and youngest entry index out.
module data_store_buffer_sb_fwd_select #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match,
    input  logic [DEPTH-1:0] occupied,
    input  logic [PTR_W-1:0] head,
    output logic             hit,
    output logic [PTR_W-1:0] sel
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (head) toward youngest, so the last match seen is the youngest one.
    always_comb begin
        hit = 1'b0;
        sel = head;
        idx = '0;
        for (int off = 0; off < DEPTH; off++) begin
            idx = head + PTR_W'(off);
            if (match[idx] && occupied[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// In-order write-back store buffer in front of data_memory, with load forwarding.
// Latency: a store accepted at edge N forwards from cycle N+1 and drains no earlier than cycle N+1.
// Backpressure: st_ready drops when full unless a drain frees the head slot in the same cycle.
// Ports: clk, reset (async, active-high); sb carries the store, load, drain grant and data_memory signals.
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    data_store_buffer_if.slave sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;

    logic              drain;
    logic              accept;
    logic              st_rdy;
    logic [DEPTH-1:0]  match_vec;
    logic [DEPTH-1:0]  occ_vec;
    logic [PTR_W-1:0]  off;
    logic              fwd_hit;
    logic [PTR_W-1:0]  fwd_idx;

    assign drain  = sb.drain_en && (cnt != '0);
    // A full buffer still takes a store when the head drains this cycle.
    assign st_rdy = (cnt < CNT_W'(DEPTH)) || drain;
    assign accept = sb.st_valid && st_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(accept) - CNT_W'(drain);
        end
    end

    // Entry storage needs no reset: occupancy is derived from head/count.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_addr[tail] <= sb.st_addr;
            ent_data[tail] <= sb.st_data;
        end
    end

    // Full and empty both have head==tail, so occupancy comes from the offset against count.
    always_comb begin
        match_vec = '0;
        occ_vec   = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PTR_W'(i) - head;
            occ_vec[i]   = {1'b0, off} < cnt;
            match_vec[i] = ent_addr[i][ADDR_W-1:WORD_LSB] == sb.ld_addr[ADDR_W-1:WORD_LSB];
        end
    end

    data_store_buffer_sb_fwd_select #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_select (
        .match    (match_vec),
        .occupied (occ_vec),
        .head     (head),
        .hit      (fwd_hit),
        .sel      (fwd_idx)
    );

    assign sb.st_ready      = st_rdy;
    assign sb.ld_hit        = fwd_hit;
    assign sb.ld_data       = fwd_hit ? ent_data[fwd_idx] : sb.mem_read_data;
    assign sb.dm_write      = drain;
    // With nothing pending, the shared address port belongs to the load.
    assign sb.dm_address    = (cnt != '0) ? ent_addr[head] : sb.ld_addr;
    assign sb.dm_write_data = ent_data[head];
    assign sb.empty         = (cnt == '0);
    assign sb.count         = cnt;

endmodule

// File: tb/tb_data_store_buffer.sv
// Testbench for data_store_buffer: directed scenarios plus random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic ram_init;
    logic [31:0] ram [16];

    int checks   = 0;
    int failures = 0;

    ent_t        q[$];
    logic [31:0] mram [16];

    always #5 clk = ~clk;

    data_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) sb ();

    data_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    // data_memory stand-in: separate read port on ld_addr, write port on dm_*.
    assign sb.mem_read_data = ram[sb.ld_addr[5:2]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'(i);
        end else if (sb.dm_write) begin
            ram[sb.dm_address[5:2]] <= sb.dm_write_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [3:0] w;
        logic [1:0] b;
        w = 4'($urandom_range(0, 15));
        b = 2'($urandom_range(0, 3));
        return {26'd0, w, b};
    endfunction

    // One cycle: drive at negedge, compare against the model, then advance the model past the next edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic de, input logic [31:0] la);
        int          n;
        logic        exp_drain;
        logic        exp_rdy;
        logic        exp_hit;
        logic [31:0] exp_ld;
        @(negedge clk);
        sb.st_valid = v;
        sb.st_addr  = a;
        sb.st_data  = d;
        sb.drain_en = de;
        sb.ld_addr  = la;
        #1;
        n         = q.size();
        exp_drain = de && (n != 0);
        exp_rdy   = (n < DEPTH) || exp_drain;
        exp_hit   = 1'b0;
        exp_ld    = mram[la[5:2]];
        foreach (q[i]) begin
            if (q[i].a[31:2] == la[31:2]) begin
                exp_hit = 1'b1;
                exp_ld  = q[i].d;
            end
        end
        check_eq("st_ready", 32'(sb.st_ready), 32'(exp_rdy));
        check_eq("count",    32'(sb.count),    32'(n));
        check_eq("empty",    32'(sb.empty),    32'(n == 0));
        check_eq("dm_write", 32'(sb.dm_write), 32'(exp_drain));
        check_eq("dm_address", sb.dm_address, (n != 0) ? q[0].a : la);
        if (n != 0) check_eq("dm_write_data", sb.dm_write_data, q[0].d);
        check_eq("ld_hit",  32'(sb.ld_hit), 32'(exp_hit));
        check_eq("ld_data", sb.ld_data, exp_ld);
        if (exp_drain) begin
            mram[q[0].a[5:2]] = q[0].d;
            void'(q.pop_front());
        end
        if (v && exp_rdy) q.push_back('{a: a, d: d});
    endtask

    task automatic drain_all();
        for (int k = 0; k < 2 * DEPTH && q.size() != 0; k++) step(1'b0, 32'h0, 32'h0, 1'b1, rand_addr());
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mram[i] = 32'(i);
        reset       = 1'b1;
        ram_init    = 1'b1;
        sb.st_valid = 1'b0;
        sb.st_addr  = '0;
        sb.st_data  = '0;
        sb.drain_en = 1'b0;
        sb.ld_addr  = 32'h30;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_count",    32'(sb.count),    32'd0);
        check_eq("rst_empty",    32'(sb.empty),    32'd1);
        check_eq("rst_st_ready", 32'(sb.st_ready), 32'd1);
        check_eq("rst_dm_write", 32'(sb.dm_write), 32'd0);
        check_eq("rst_ld_hit",   32'(sb.ld_hit),   32'd0);
        check_eq("rst_ld_data",  sb.ld_data,       32'd12);
        reset    = 1'b0;
        ram_init = 1'b0;

        // Single store, then forwarded load.
        step(1'b1, 32'h10, 32'hAAAA0001, 1'b0, 32'h10);
        step(1'b0, 32'h0,  32'h0,        1'b0, 32'h10);
        check_eq("t1_count",   32'(sb.count),  32'd1);
        check_eq("t1_ld_hit",  32'(sb.ld_hit), 32'd1);
        check_eq("t1_ld_data", sb.ld_data,     32'hAAAA0001);
        drain_all();

        // Fill, refuse a fifth store, then accept it alongside a drain.
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 32'h3C);
        step(1'b1, 32'h14, 32'hB000_0055, 1'b0, 32'h0);
        check_eq("t2_full_rdy", 32'(sb.st_ready), 32'd0);
        step(1'b1, 32'h14, 32'hB000_0055, 1'b1, 32'h0);
        check_eq("t2_drain_rdy", 32'(sb.st_ready),  32'd1);
        check_eq("t2_dm_write",  32'(sb.dm_write),  32'd1);
        check_eq("t2_dm_addr",   sb.dm_address,     32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check_eq("t2_count", 32'(sb.count), 32'd4);
        drain_all();

        // Duplicate address: youngest forwards, last write wins in memory.
        step(1'b1, 32'h20, 32'h1, 1'b0, 32'h0);
        step(1'b1, 32'h20, 32'h2, 1'b0, 32'h0);
        step(1'b0, 32'h0,  32'h0, 1'b0, 32'h22);
        check_eq("t3_ld_hit",  32'(sb.ld_hit), 32'd1);
        check_eq("t3_ld_data", sb.ld_data,     32'h2);
        drain_all();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h22);
        check_eq("t3_post_hit",  32'(sb.ld_hit), 32'd0);
        check_eq("t3_post_data", sb.ld_data,     32'h2);

        // Miss passes memory through.
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h30);
        check_eq("t4_ld_hit",  32'(sb.ld_hit), 32'd0);
        check_eq("t4_ld_data", sb.ld_data,     32'hC);

        // Stores interleaved with drain grants, wrapping the pointers.
        for (int i = 0; i < 6; i++) step(1'b1, 32'((i + 1) * 4), 32'hC000_0000 + 32'(i), 1'(i % 2), rand_addr());
        drain_all();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), rand_addr(), $urandom(),
                 1'($urandom_range(0, 99) < 45), rand_addr());
        end
        drain_all();

        // Reset with three stores pending and a drain granted: nothing of them reaches memory.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h30 + 32'(i * 4), 32'hDEAD_0000 + 32'(i), 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h34);
        @(negedge clk);
        sb.st_valid = 1'b0;
        sb.drain_en = 1'b1;
        sb.ld_addr  = 32'h34;
        #1;
        check_eq("t6_pre_dm_write", 32'(sb.dm_write), 32'd1);
        check_eq("t6_pre_count",    32'(sb.count),    32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_count",    32'(sb.count),    32'd0);
        check_eq("t6_empty",    32'(sb.empty),    32'd1);
        check_eq("t6_dm_write", 32'(sb.dm_write), 32'd0);
        check_eq("t6_ld_hit",   32'(sb.ld_hit),   32'd0);
        check_eq("t6_ld_data",  sb.ld_data,       mram[13]);
        q.delete();
        @(negedge clk);
        reset       = 1'b0;
        sb.drain_en = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h38);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h3C);

        @(negedge clk);
        for (int i = 0; i < 16; i++) check_eq($sformatf("ram[%0d]", i), ram[i], mram[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
